// File: rtl/xilinx_pcie_dma_rd_sched.sv
// PCIe DMA read scheduler: splits one host read into MRRS-sized memory-read
// requests, caps requests in flight and reports each accepted request to the
// completion path.
// Build option: define DMA_RD_4K_SPLIT_EN to also stop requests at 4 KB
// address boundaries; without it chunks are limited by MRRS and length only.
module xilinx_pcie_dma_rd_sched #(
    parameter int unsigned P_MAX_OUTSTANDING = 8,
    parameter int unsigned P_CNT_WIDTH       = 4,
    parameter int unsigned P_XFER_LEN_WIDTH  = 20
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        start,
    input  logic [31:0]                 xfer_addr,
    input  logic [P_XFER_LEN_WIDTH-1:0] xfer_len_dw,
    input  logic [2:0]                  cfg_mrrs,
    input  logic                        cpl_done,
    output logic [31:0]                 dma_read_addr,
    output logic [9:0]                  dma_read_len,
    output logic                        dma_read_valid,
    input  logic                        dma_read_done,
    input  logic [7:0]                  current_tag,
    output logic                        issued_valid,
    output logic [7:0]                  issued_tag,
    output logic [31:0]                 issued_addr,
    output logic [10:0]                 issued_len,
    output logic                        busy,
    output logic                        xfer_done,
    output logic [P_CNT_WIDTH-1:0]      outstanding
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_THROTTLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_DRAIN
    } state_t;

    localparam logic [P_CNT_WIDTH-1:0] C_MAX = P_CNT_WIDTH'(P_MAX_OUTSTANDING);

    state_t                      state_q, state_d;
    logic [31:0]                 addr_q, addr_d;
    logic [P_XFER_LEN_WIDTH-1:0] rem_q, rem_d;
    logic [10:0]                 chunk_q, chunk_d;
    logic [7:0]                  tag_q, tag_d;
    logic [P_CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic                        iss_valid_q, iss_valid_d;
    logic [7:0]                  iss_tag_q, iss_tag_d;
    logic [31:0]                 iss_addr_q, iss_addr_d;
    logic [10:0]                 iss_len_q, iss_len_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic [2:0]                  mrrs_sel;
    logic [10:0]                 mrrs_dw;
    logic [10:0]                 chunk_calc;
`ifdef DMA_RD_4K_SPLIT_EN
    logic [10:0]                 dw_to_4k;
`endif
    logic                        accept;
    logic                        cpl_ok;

    // Size of the next request: remaining length capped by MRRS (and the 4 KB page edge when enabled).
    always_comb begin
        mrrs_sel = (cfg_mrrs > 3'd5) ? 3'd5 : cfg_mrrs;
        mrrs_dw  = 11'd32 << mrrs_sel;
        if (32'(rem_q) < 32'(mrrs_dw)) begin
            chunk_calc = 11'(rem_q);
        end else begin
            chunk_calc = mrrs_dw;
        end
`ifdef DMA_RD_4K_SPLIT_EN
        dw_to_4k = 11'd1024 - {1'b0, addr_q[11:2]};
        if (dw_to_4k < chunk_calc) begin
            chunk_calc = dw_to_4k;
        end
`endif
    end

    assign accept = (state_q == S_ISSUE) && dma_read_done;
    assign cpl_ok = cpl_done && (cnt_q != '0);

    // Next-state, datapath and registered-output logic for the request sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        chunk_d     = chunk_q;
        tag_d       = tag_q;
        valid_d     = 1'b0;
        iss_valid_d = 1'b0;
        iss_tag_d   = iss_tag_q;
        iss_addr_d  = iss_addr_q;
        iss_len_d   = iss_len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case ({accept, cpl_ok})
            2'b10:   cnt_d = cnt_q + P_CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - P_CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (xfer_len_dw != '0) begin
                        addr_d  = xfer_addr & ~32'h3;
                        rem_d   = xfer_len_dw;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                chunk_d = chunk_calc;
                if (cnt_q == C_MAX) begin
                    state_d = S_THROTTLE;
                end else begin
                    tag_d   = current_tag;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_THROTTLE: begin
                if (cnt_q < C_MAX) begin
                    tag_d   = current_tag;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dma_read_done) begin
                    iss_valid_d = 1'b1;
                    iss_tag_d   = tag_q;
                    iss_addr_d  = addr_q;
                    iss_len_d   = chunk_q;
                    addr_d      = addr_q + {19'b0, chunk_q, 2'b00};
                    rem_d       = rem_q - P_XFER_LEN_WIDTH'(chunk_q);
                    state_d     = S_WAIT_LOW;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_WAIT_LOW: begin
                // Holding here until the TX flag drops keeps a long done level from issuing twice.
                if (!dma_read_done) begin
                    state_d = (rem_q != '0) ? S_CALC : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_tag_q   <= '0;
            iss_addr_q  <= '0;
            iss_len_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            chunk_q     <= chunk_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            iss_valid_q <= iss_valid_d;
            iss_tag_q   <= iss_tag_d;
            iss_addr_q  <= iss_addr_d;
            iss_len_q   <= iss_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dma_read_addr  = addr_q;
    assign dma_read_len   = chunk_q[9:0];
    assign dma_read_valid = valid_q;
    assign issued_valid   = iss_valid_q;
    assign issued_tag     = iss_tag_q;
    assign issued_addr    = iss_addr_q;
    assign issued_len     = iss_len_q;
    assign busy           = busy_q;
    assign xfer_done      = done_q;
    assign outstanding    = cnt_q;

endmodule

// File: tb/tb_xilinx_pcie_dma_rd_sched.sv
// Testbench for xilinx_pcie_dma_rd_sched: randomized TX/RX responders with a
// chunk-list reference model; a second instance with two slots covers throttling.
module tb_xilinx_pcie_dma_rd_sched;

    localparam int unsigned A_MAX = 8;

    logic        i_clk;
    logic        i_rst;

    logic        start;
    logic [31:0] xfer_addr;
    logic [19:0] xfer_len_dw;
    logic [2:0]  cfg_mrrs;
    logic        cpl_done;
    logic [31:0] dma_read_addr;
    logic [9:0]  dma_read_len;
    logic        dma_read_valid;
    logic        dma_read_done;
    logic [7:0]  current_tag;
    logic        issued_valid;
    logic [7:0]  issued_tag;
    logic [31:0] issued_addr;
    logic [10:0] issued_len;
    logic        busy;
    logic        xfer_done;
    logic [3:0]  outstanding;

    logic        b_start;
    logic [31:0] b_xfer_addr;
    logic [19:0] b_xfer_len_dw;
    logic [2:0]  b_cfg_mrrs;
    logic        b_cpl_done;
    logic [31:0] b_dma_read_addr;
    logic [9:0]  b_dma_read_len;
    logic        b_dma_read_valid;
    logic        b_dma_read_done;
    logic [7:0]  b_current_tag;
    logic        b_issued_valid;
    logic [7:0]  b_issued_tag;
    logic [31:0] b_issued_addr;
    logic [10:0] b_issued_len;
    logic        b_busy;
    logic        b_xfer_done;
    logic [1:0]  b_outstanding;

    int unsigned n_vec;
    int unsigned n_err;

    xilinx_pcie_dma_rd_sched #(
        .P_MAX_OUTSTANDING(A_MAX),
        .P_CNT_WIDTH(4),
        .P_XFER_LEN_WIDTH(20)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .start(start), .xfer_addr(xfer_addr),
        .xfer_len_dw(xfer_len_dw), .cfg_mrrs(cfg_mrrs), .cpl_done(cpl_done),
        .dma_read_addr(dma_read_addr), .dma_read_len(dma_read_len),
        .dma_read_valid(dma_read_valid), .dma_read_done(dma_read_done),
        .current_tag(current_tag), .issued_valid(issued_valid), .issued_tag(issued_tag),
        .issued_addr(issued_addr), .issued_len(issued_len), .busy(busy),
        .xfer_done(xfer_done), .outstanding(outstanding)
    );

    xilinx_pcie_dma_rd_sched #(
        .P_MAX_OUTSTANDING(2),
        .P_CNT_WIDTH(2),
        .P_XFER_LEN_WIDTH(20)
    ) u_dut_thr (
        .i_clk(i_clk), .i_rst(i_rst), .start(b_start), .xfer_addr(b_xfer_addr),
        .xfer_len_dw(b_xfer_len_dw), .cfg_mrrs(b_cfg_mrrs), .cpl_done(b_cpl_done),
        .dma_read_addr(b_dma_read_addr), .dma_read_len(b_dma_read_len),
        .dma_read_valid(b_dma_read_valid), .dma_read_done(b_dma_read_done),
        .current_tag(b_current_tag), .issued_valid(b_issued_valid), .issued_tag(b_issued_tag),
        .issued_addr(b_issued_addr), .issued_len(b_issued_len), .busy(b_busy),
        .xfer_done(b_xfer_done), .outstanding(b_outstanding)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // One full transfer on the main instance, checked against a chunk list built from the rules.
    task automatic run_xfer(input logic [31:0] addr, input int unsigned len, input logic [2:0] mrrs,
                            input bit cpl_hold, input int unsigned hold_min, input int unsigned hold_max,
                            input bit poke_start, output int unsigned peak);
        logic [31:0] q_addr[$];
        int unsigned q_len[$];
        logic [31:0] a;
        logic [7:0]  tag_at;
        int unsigned rem, c, lim, pg, n, idx, mo, budget, delay, hold_left;
        bit          done_seen, exp_iss, dec, poked;

        a   = addr & ~32'h3;
        rem = len;
        lim = 32 << ((mrrs > 3'd5) ? 5 : int'(mrrs));
        while (rem != 0) begin
            c = (rem < lim) ? rem : lim;
`ifdef DMA_RD_4K_SPLIT_EN
            pg = 1024 - ((a >> 2) % 1024);
            if (c > pg) c = pg;
`else
            pg = 0;
`endif
            q_addr.push_back(a);
            q_len.push_back(c);
            a   = a + c * 4;
            rem = rem - c;
        end
        n = q_len.size();

        cfg_mrrs      = mrrs;
        xfer_addr     = addr;
        xfer_len_dw   = 20'(len);
        start         = 1'b1;
        dma_read_done = 1'b0;
        cpl_done      = 1'b0;
        tick;
        start = 1'b0;

        idx = 0; mo = 0; peak = 0; budget = 0; hold_left = 0; poked = 0; done_seen = 0;
        delay = $urandom_range(0, 2);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end

        while (!done_seen && budget < 20000) begin
            if (hold_left != 0) begin
                dma_read_done = 1'b1;
                hold_left--;
            end else if (dma_read_valid === 1'b1 && delay == 0) begin
                dma_read_done = 1'b1;
                hold_left     = $urandom_range(hold_min, hold_max) - 1;
                delay         = $urandom_range(0, 2);
            end else begin
                dma_read_done = 1'b0;
                if (dma_read_valid === 1'b1 && delay != 0) delay--;
            end
            exp_iss = dma_read_done && (dma_read_valid === 1'b1);
            tag_at  = current_tag;
            if (cpl_hold) cpl_done = (idx == n) && ($urandom_range(0, 1) == 1);
            else          cpl_done = ($urandom_range(0, 3) == 0);
            if (poke_start && !poked && idx == 1) begin
                start       = 1'b1;
                xfer_addr   = $urandom;
                xfer_len_dw = 20'($urandom_range(1, 500));
                poked       = 1;
            end
            tick;
            start = 1'b0;
            budget++;

            dec = cpl_done && (mo != 0);
            mo  = mo + (exp_iss ? 1 : 0) - (dec ? 1 : 0);
            if (mo > peak) peak = mo;

            n_vec++;
            if (issued_valid !== exp_iss) begin
                n_err++;
                $display("FAIL issued_valid: got %b want %b (req %0d)", issued_valid, exp_iss, idx);
            end
            if (exp_iss) begin
                n_vec++;
                if (idx >= n) begin
                    n_err++;
                    $display("FAIL extra_request: got request %0d want only %0d", idx, n);
                end else if (issued_tag !== tag_at || issued_addr !== q_addr[idx] ||
                             issued_len !== 11'(q_len[idx])) begin
                    n_err++;
                    $display("FAIL issued_info: got tag %h addr %h len %0d want tag %h addr %h len %0d",
                             issued_tag, issued_addr, issued_len, tag_at, q_addr[idx], q_len[idx]);
                end
                idx++;
                current_tag = 8'($urandom);
            end

            n_vec++;
            if (outstanding !== 4'(mo)) begin
                n_err++;
                $display("FAIL outstanding: got %0d want %0d", outstanding, mo);
            end

            if (dma_read_valid === 1'b1) begin
                n_vec++;
                if (idx >= n || mo >= A_MAX) begin
                    n_err++;
                    $display("FAIL valid_unexpected: got valid with req %0d of %0d, %0d in flight want none", idx, n, mo);
                end else if (dma_read_addr !== q_addr[idx] || dma_read_len !== 10'(q_len[idx])) begin
                    n_err++;
                    $display("FAIL dma_req: got addr %h len %0d want addr %h len %0d",
                             dma_read_addr, dma_read_len, q_addr[idx], 10'(q_len[idx]));
                end
            end

            n_vec++;
            if (xfer_done === 1'b1) begin
                done_seen = 1;
                if (idx != n || mo != 0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL xfer_done_early: got done with %0d/%0d issued, %0d in flight, busy %b want all issued, 0, 0",
                             idx, n, mo, busy);
                end
            end else if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_during: got %b want 1", busy);
            end
        end

        cpl_done      = 1'b0;
        dma_read_done = 1'b0;
        n_vec++;
        if (!done_seen) begin
            n_err++;
            $display("FAIL xfer_timeout: got %0d/%0d requests after %0d cycles want xfer_done", idx, n, budget);
        end
        tick;
        n_vec++;
        if ({xfer_done, busy, dma_read_valid, outstanding} !== 7'b0) begin
            n_err++;
            $display("FAIL after_done: got done %b busy %b valid %b out %0d want all 0",
                     xfer_done, busy, dma_read_valid, outstanding);
        end
    endtask

    task automatic b_step(input bit cpl, inout int unsigned cnt);
        b_cpl_done      = cpl;
        b_dma_read_done = (b_dma_read_valid === 1'b1) && !b_dma_read_done;
        tick;
        b_start    = 1'b0;
        b_cpl_done = 1'b0;
        if (b_issued_valid === 1'b1) cnt++;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        start = 0; xfer_addr = '0; xfer_len_dw = '0; cfg_mrrs = '0; cpl_done = 0;
        dma_read_done = 0; current_tag = 8'h5A;
        b_start = 0; b_xfer_addr = '0; b_xfer_len_dw = '0; b_cfg_mrrs = '0; b_cpl_done = 0;
        b_dma_read_done = 0; b_current_tag = 8'h00;
        repeat (3) tick;
        n_vec++;
        if ({dma_read_valid, dma_read_addr, dma_read_len, issued_valid, issued_tag, issued_addr,
             issued_len, busy, xfer_done, outstanding} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid %b addr %h len %0d iv %b busy %b done %b out %0d want all 0",
                     dma_read_valid, dma_read_addr, dma_read_len, issued_valid, busy, xfer_done, outstanding);
        end
        i_rst = 1'b0;
        tick;
    endtask

    task automatic test_zero_len;
        cfg_mrrs = 3'd2; xfer_addr = 32'h0000_4000; xfer_len_dw = '0; start = 1'b1;
        tick;
        start = 1'b0;
        n_vec++;
        if (xfer_done !== 1'b1 || busy !== 1'b0 || dma_read_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len: got done %b busy %b valid %b want 1 0 0", xfer_done, busy, dma_read_valid);
        end
        tick;
        n_vec++;
        if (xfer_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_pulse: got done %b busy %b want 0 0", xfer_done, busy);
        end
    endtask

    task automatic test_mrrs_split;
        int unsigned peak;
        run_xfer(32'h0, 100, 3'd0, 1'b1, 1, 1, 1'b0, peak);
        n_vec++;
        if (peak != 4) begin
            n_err++;
            $display("FAIL mrrs_split_peak: got %0d want 4", peak);
        end
    endtask

    task automatic test_reset_mid;
        int unsigned cnt, guard;
        cfg_mrrs = 3'd0; xfer_addr = 32'h0000_2000; xfer_len_dw = 20'd1024; start = 1'b1;
        tick;
        start = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 2 && guard < 100) begin
            dma_read_done = (dma_read_valid === 1'b1) && !dma_read_done;
            tick;
            guard++;
            if (issued_valid === 1'b1) cnt++;
        end
        n_vec++;
        if (cnt != 2) begin
            n_err++;
            $display("FAIL reset_mid_issue: got %0d requests want 2", cnt);
        end
        dma_read_done = 1'b0;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        n_vec++;
        if ({dma_read_valid, dma_read_addr, dma_read_len, issued_valid, issued_tag, issued_addr,
             issued_len, busy, xfer_done, outstanding} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got valid %b addr %h len %0d iv %b busy %b out %0d want all 0",
                     dma_read_valid, dma_read_addr, dma_read_len, issued_valid, busy, outstanding);
        end
        cpl_done = 1'b1;
        tick;
        cpl_done = 1'b0;
        n_vec++;
        if (outstanding !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stale_cpl: got out %0d busy %b want 0 0", outstanding, busy);
        end
    endtask

    task automatic test_throttle;
        int unsigned cnt;
        bit seen;
        cnt = 0; seen = 0;
        b_cfg_mrrs = 3'd0; b_xfer_addr = 32'h0000_4000; b_xfer_len_dw = 20'd128; b_start = 1'b1;
        b_step(1'b0, cnt);
        repeat (30) b_step(1'b0, cnt);
        n_vec++;
        if (cnt != 2 || b_dma_read_valid !== 1'b0 || b_outstanding !== 2'd2) begin
            n_err++;
            $display("FAIL throttle_hold: got %0d reqs valid %b out %0d want 2 0 2", cnt, b_dma_read_valid, b_outstanding);
        end
        for (int unsigned k = 3; k <= 4; k++) begin
            b_step(1'b1, cnt);
            repeat (15) b_step(1'b0, cnt);
            n_vec++;
            if (cnt != k || b_dma_read_valid !== 1'b0 || b_outstanding !== 2'd2) begin
                n_err++;
                $display("FAIL throttle_release: got %0d reqs valid %b out %0d want %0d 0 2",
                         cnt, b_dma_read_valid, b_outstanding, k);
            end
        end
        n_vec++;
        if (b_xfer_done !== 1'b0 || b_busy !== 1'b1) begin
            n_err++;
            $display("FAIL throttle_drain: got done %b busy %b want 0 1", b_xfer_done, b_busy);
        end
        for (int unsigned k = 0; k < 10 && !seen; k++) begin
            b_step(1'b1, cnt);
            if (b_xfer_done === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || cnt != 4 || b_outstanding !== 2'd0 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL throttle_done: got seen %b reqs %0d out %0d busy %b want 1 4 0 0",
                     seen, cnt, b_outstanding, b_busy);
        end
    endtask

    task automatic test_random;
        int unsigned peak;
        logic [31:0] ra;
        for (int unsigned i = 0; i < 25; i++) begin
            ra = $urandom;
            if (i % 4 == 0) ra = 32'hFFFF_F000 | (ra & 32'h0000_0FFF);
            run_xfer(ra, $urandom_range(1, 2000), 3'($urandom_range(0, 7)), 1'b0, 1, 3, 1'b1, peak);
        end
    endtask

    initial begin
        int unsigned peak;
        n_vec = 0;
        n_err = 0;
        test_reset;
        run_xfer(32'h0000_1000, 16, 3'd0, 1'b0, 1, 1, 1'b0, peak);
        test_mrrs_split;
        run_xfer(32'h0000_0FF0, 8, 3'd5, 1'b0, 1, 1, 1'b0, peak);
        run_xfer(32'h0000_0000, 1024, 3'd5, 1'b0, 1, 2, 1'b0, peak);
        run_xfer(32'h0000_3003, 200, 3'd1, 1'b0, 3, 3, 1'b0, peak);
        run_xfer(32'hFFFF_FF80, 100, 3'd7, 1'b0, 1, 2, 1'b0, peak);
        test_zero_len;
        test_reset_mid;
        run_xfer(32'h0000_2000, 300, 3'd2, 1'b0, 1, 3, 1'b1, peak);
        test_throttle;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xilinx_pcie_dma_rd_sched.md
Name: xilinx_pcie_dma_rd_sched

Overview:
Scheduler that turns one large host-memory read into a series of PCIe memory-read TLP requests. It drives the DMA read request interface of the PCIe TX engine.
- Each chunk is limited by the max read request size. With the optional feature, chunks also never cross a 4 KB boundary.
- Caps the number of outstanding (uncompleted) requests.
- Reports each issued tag/address/length to the RX completion path.

Parameters:
P_MAX_OUTSTANDING, 8, max requests in flight (1..255)
P_CNT_WIDTH, 4, width of outstanding counter; must hold P_MAX_OUTSTANDING
P_XFER_LEN_WIDTH, 20, width of total transfer length in DW

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; latch xfer_addr/xfer_len_dw
xfer_addr  in  32  host byte address; bits [1:0] ignored (DW aligned)
xfer_len_dw  in  P_XFER_LEN_WIDTH  total DWs to read
cfg_mrrs  in  3  PCIe MRRS encoding: 0=32DW … 5=1024DW; 6/7 treated as 5
cpl_done  in  1  1-cycle pulse: one request fully completed (from RX)
dma_read_addr  out  32  request address to TX engine
dma_read_len  out  10  request length in DW; 1024 encoded as 0
dma_read_valid  out  1  request valid to TX engine
dma_read_done  in  1  TX engine acceptance flag (level, ≥1 cycle)
current_tag  in  8  tag the TX engine will use for the next request
issued_valid  out  1  1-cycle pulse per accepted request
issued_tag  out  8  tag of accepted request
issued_addr  out  32  address of accepted request
issued_len  out  11  length of accepted request in DW (1..1024, unencoded)
busy  out  1  high from start until xfer_done
xfer_done  out  1  1-cycle pulse: all chunks issued and completed
outstanding  out  P_CNT_WIDTH  current in-flight count

Behaviour:
Reset:
- Every output is 0; state is IDLE; counters and address/remaining registers are cleared.
- Reset mid-transfer abandons the transfer. Completions arriving later are not tracked (cpl_done is ignored while outstanding==0).

IDLE:
- start with xfer_len_dw!=0: latch addr ({xfer_addr[31:2],2'b00}) and remaining, set busy, go to CALC.
- start with len 0: xfer_done pulses the next cycle; busy stays 0.
- start while busy: ignored.

CALC (1 cycle):
- chunk = min(remaining, mrrs_dw, dw_to_4k), where mrrs_dw = 32<<cfg_mrrs and dw_to_4k = 1024 - addr[11:2].
- Register chunk.
- If outstanding==P_MAX_OUTSTANDING, go to THROTTLE; else go to ISSUE.

THROTTLE: wait until outstanding<P_MAX_OUTSTANDING, then go to ISSUE.

ISSUE:
- dma_read_valid=1; addr/len stable. Tag is snapshotted from current_tag when entering ISSUE. current_tag is stable until acceptance.
- On dma_read_done==1:
  - valid drops the same cycle (registered: next cycle low).
  - issued_* pulse with the snapshot tag.
  - outstanding+1; addr+=chunk*4; remaining-=chunk.
  - Go to WAIT_LOW.

WAIT_LOW:
- Wait for dma_read_done==0. This guarantees one issue per TX acceptance.
- Then: if remaining!=0, go to CALC; else go to DRAIN.

DRAIN: when outstanding==0, pulse xfer_done, clear busy, go to IDLE.

Outstanding counter:
- Simultaneous issue and cpl_done: net change 0.
- cpl_done at 0: no change (no underflow).
- Counter never exceeds P_MAX_OUTSTANDING.

Address arithmetic: 32-bit, wraps modulo 2^32 without error.

Throughput: one request per TX round trip. Minimum 3 cycles between valid assertions (CALC, ISSUE, WAIT_LOW).

Optional Feature:
DMA_RD_4K_SPLIT_EN
- Defined: the dw_to_4k term participates in the chunk minimum, so no request crosses a 4 KB address boundary (PCIe compliant).
- Undefined: the term is omitted; chunk = min(remaining, mrrs_dw).

Test Plan:
1. Single small read: cfg_mrrs=0, start addr=0x1000, len=16 -> one request addr 0x1000, len 16, tag=current_tag. Then 4 cpl_done pulses are not needed: one cpl_done -> xfer_done, busy low.
2. MRRS split: cfg_mrrs=0, addr=0x0, len=100 -> requests (0x0,32),(0x80,32),(0x100,32),(0x180,4); outstanding peaks 4; xfer_done only after the 4th cpl_done.
3. 4K split (macro defined): cfg_mrrs=5, addr=0x0FF0, len=8 -> (0x0FF0,4),(0x1000,4). With macro undefined -> single (0x0FF0,8).
4. Throttle: P_MAX_OUTSTANDING=2, no cpl_done, cfg_mrrs=0, len=128 -> exactly 2 requests, then valid stays low. Each cpl_done releases exactly one more request.
5. Length encoding: cfg_mrrs=5, addr=0x0, len=1024 -> dma_read_len=0, issued_len=1024.
6. Reset mid-transfer, and TX done held high for multiple cycles:
   - Reset after the 2nd request -> all outputs 0 next cycle; new start works normally.
   - dma_read_done held 3 cycles -> only one issued_valid pulse.
